// File: rtl/clk_period_monitor.sv
// Module: clk_period_monitor
// Measures a slow generated clock inside the 50 MHz domain. The slow clock is
// synchronised, its rising edges detected, and each complete period is
// reported as a period length and high time in fast-clock cycles. Periods
// outside EXP_PERIOD +/- TOL raise errO; no rising edge for TIMEOUT cycles
// raises lostO.
// Optional feature macro: CLKMON_STICKY_EN adds errClrI / errStickyO, a
// latched fault flag that holds until cleared while no fault is present.
module clk_period_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 5,
    parameter int TOL        = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk50mhzI,
    input  logic             nRst,
    input  logic             clkSlowI,
    output logic [CNT_W-1:0] periodO,
    output logic [CNT_W-1:0] highO,
    output logic             validO,
    output logic             errO,
    output logic             lostO
`ifdef CLKMON_STICKY_EN
  , input  logic             errClrI,
    output logic             errStickyO
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LO_BOUND    = (EXP_PERIOD > TOL) ? CNT_W'(EXP_PERIOD - TOL) : '0;
    localparam logic [CNT_W-1:0] HI_BOUND    = CNT_W'(EXP_PERIOD + TOL);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_MEAS = 2'd1,
        ST_LOST = 2'd2
    } stateT;

    stateT            state;
    stateT            nextState;
    logic             syncMeta;
    logic             syncLevel;
    logic             levelDly;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] periodVal;
    logic [CNT_W-1:0] highVal;
    logic             periodBad;
    logic             capture;

    // Two-flop synchroniser plus a delayed copy of the synced level for edge detection
    always_ff @(posedge clk50mhzI or negedge nRst) begin
        if (!nRst) begin
            syncMeta  <= 1'b0;
            syncLevel <= 1'b0;
            levelDly  <= 1'b0;
        end else begin
            syncMeta  <= clkSlowI;
            syncLevel <= syncMeta;
            levelDly  <= syncLevel;
        end
    end

    assign rise = syncLevel & ~levelDly;

    // Saturating period and high-time counters, restarted on every rising edge
    always_ff @(posedge clk50mhzI or negedge nRst) begin
        if (!nRst) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= '0;
            hcnt <= '0;
        end else begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + ONE;
            end
            if (syncLevel && (hcnt != CNT_MAX)) begin
                hcnt <= hcnt + ONE;
            end
        end
    end

    // The current cycle belongs to the period being closed, so fold it into both values
    always_comb begin
        periodVal = (cnt == CNT_MAX) ? cnt : cnt + ONE;
        highVal   = hcnt;
        if (syncLevel && (hcnt != CNT_MAX)) begin
            highVal = hcnt + ONE;
        end
    end

    assign periodBad = (periodVal < LO_BOUND) || (periodVal > HI_BOUND);

    // State register
    always_ff @(posedge clk50mhzI or negedge nRst) begin
        if (!nRst) begin
            state <= ST_WAIT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a rise in the same cycle as the timeout takes priority
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (rise) begin
                    nextState = ST_MEAS;
                end else if (cnt == TIMEOUT_CNT) begin
                    nextState = ST_LOST;
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (cnt == TIMEOUT_CNT) begin
                    nextState = ST_LOST;
                end
            end
            ST_LOST: begin
                if (rise) begin
                    nextState = ST_MEAS;
                end
            end
            default: begin
                nextState = ST_WAIT;
            end
        endcase
    end

    // Measurement result registers; errO holds until the next completed period
    always_ff @(posedge clk50mhzI or negedge nRst) begin
        if (!nRst) begin
            periodO <= '0;
            highO   <= '0;
            validO  <= 1'b0;
            errO    <= 1'b0;
        end else begin
            validO <= capture;
            if (capture) begin
                periodO <= periodVal;
                highO   <= highVal;
                errO    <= periodBad;
            end
        end
    end

    assign lostO = (state == ST_LOST);

`ifdef CLKMON_STICKY_EN
    // Latched fault flag; a live fault always wins over a clear request
    always_ff @(posedge clk50mhzI or negedge nRst) begin
        if (!nRst) begin
            errStickyO <= 1'b0;
        end else if (errO || lostO) begin
            errStickyO <= 1'b1;
        end else if (errClrI) begin
            errStickyO <= 1'b0;
        end
    end
`else
    // Without the sticky option there is no latched fault state to maintain.
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Testbench for clk_period_monitor.
// Drives whole slow-clock periods aligned to the fast clock's falling edge,
// pushes the period each rising edge is expected to close into a scoreboard,
// and pops/compares whenever validO is seen. Directed checks cover reset,
// out-of-range periods, loss of clock, mid-period reset and the timeout
// boundary. Build with CLKMON_STICKY_EN defined to also check the sticky flag.
module tb_clk_period_monitor;

    localparam int CNT_W      = 16;
    localparam int EXP_PERIOD = 5;
    localparam int TOL        = 0;
    localparam int TIMEOUT    = 64;

    typedef struct {
        int period;
        int high;
        bit err;
    } expT;

    logic             clk50mhzI;
    logic             nRst;
    logic             clkSlowI;
    logic [CNT_W-1:0] periodO;
    logic [CNT_W-1:0] highO;
    logic             validO;
    logic             errO;
    logic             lostO;
`ifdef CLKMON_STICKY_EN
    logic             errClrI;
    logic             errStickyO;
`endif

    expT sbQ[$];
    expT expItem;
    int  testCount  = 0;
    int  failCount  = 0;
    int  validCount = 0;
    int  vcBefore;
    bit  armed      = 1'b0;
    int  prevHigh   = 0;
    int  prevLow    = 0;

    clk_period_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk50mhzI (clk50mhzI),
        .nRst      (nRst),
        .clkSlowI  (clkSlowI),
        .periodO   (periodO),
        .highO     (highO),
        .validO    (validO),
        .errO      (errO),
        .lostO     (lostO)
`ifdef CLKMON_STICKY_EN
      , .errClrI   (errClrI),
        .errStickyO(errStickyO)
`endif
    );

    // 50 MHz fast clock
    initial clk50mhzI = 1'b0;
    always #10 clk50mhzI = ~clk50mhzI;

    function automatic bit expErr(input int p);
        int lo;
        lo = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
        return (p < lo) || (p > EXP_PERIOD + TOL);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One slow period: rise, high for h cycles, low for l cycles
    task automatic applyStimulus(input int h, input int l);
        if (armed && (prevHigh + prevLow) < TIMEOUT + 2) begin
            sbQ.push_back('{prevHigh + prevLow, prevHigh, expErr(prevHigh + prevLow)});
        end
        armed    = 1'b1;
        clkSlowI = 1'b1;
        repeat (h) @(negedge clk50mhzI);
        clkSlowI = 1'b0;
        repeat (l) @(negedge clk50mhzI);
        prevHigh = h;
        prevLow  = l;
    endtask

    // Scoreboard consumer: every validO pulse must match the oldest expectation
    always @(negedge clk50mhzI) begin
        if (nRst && validO) begin
            validCount++;
            if (sbQ.size() == 0) begin
                checkOutput("spuriousValid", 32'(validO), 32'd0);
            end else begin
                expItem = sbQ.pop_front();
                checkOutput("periodO", 32'(periodO), 32'(expItem.period));
                checkOutput("highO", 32'(highO), 32'(expItem.high));
                checkOutput("errO", 32'(errO), 32'(expItem.err));
            end
        end
    end

    initial begin
        nRst     = 1'b1;
        clkSlowI = 1'b0;
`ifdef CLKMON_STICKY_EN
        errClrI  = 1'b0;
`endif
        #5 nRst = 1'b0;
        repeat (3) @(negedge clk50mhzI);
        checkOutput("resetPeriodO", 32'(periodO), 32'd0);
        checkOutput("resetHighO", 32'(highO), 32'd0);
        checkOutput("resetValidO", 32'(validO), 32'd0);
        checkOutput("resetErrO", 32'(errO), 32'd0);
        checkOutput("resetLostO", 32'(lostO), 32'd0);
`ifdef CLKMON_STICKY_EN
        checkOutput("resetSticky", 32'(errStickyO), 32'd0);
`endif
        nRst = 1'b1;
        @(negedge clk50mhzI);

        // First edge after reset only arms the measurement
        applyStimulus(2, 3);
        checkOutput("firstEdgeNoValid", 32'(validCount), 32'd0);

        // Nominal 2 high / 3 low periods
        for (int i = 0; i < 4; i++) applyStimulus(2, 3);
        checkOutput("nominalLostO", 32'(lostO), 32'd0);

        // Stretched period of 7, then back to nominal
        applyStimulus(2, 5);
        applyStimulus(2, 3);
        applyStimulus(2, 3);
        checkOutput("errClearedByGood", 32'(errO), 32'd0);
`ifdef CLKMON_STICKY_EN
        checkOutput("stickyHolds", 32'(errStickyO), 32'd1);
        errClrI = 1'b1;
        applyStimulus(2, 3);
        errClrI = 1'b0;
        checkOutput("stickyCleared", 32'(errStickyO), 32'd0);
`endif

        // Bad period followed by a dead clock
        applyStimulus(2, 5);
        applyStimulus(2, 70);
        checkOutput("lostAsserted", 32'(lostO), 32'd1);
        checkOutput("errHeldInLost", 32'(errO), 32'd1);
`ifdef CLKMON_STICKY_EN
        errClrI = 1'b1;
        @(negedge clk50mhzI);
        errClrI = 1'b0;
        prevLow = prevLow + 1;
        checkOutput("stickyNoClearLost", 32'(errStickyO), 32'd1);
`endif
        vcBefore = validCount;
        applyStimulus(2, 3);
        checkOutput("lostReleased", 32'(lostO), 32'd0);
        checkOutput("noValidAfterLost", 32'(validCount), 32'(vcBefore));
        checkOutput("errKeptAfterLost", 32'(errO), 32'd1);
        applyStimulus(2, 3);

        // Reset in the middle of a period
        applyStimulus(2, 2);
        checkOutput("drainedBeforeReset", 32'(sbQ.size()), 32'd0);
        nRst  = 1'b0;
        armed = 1'b0;
        @(negedge clk50mhzI);
        checkOutput("midResetPeriodO", 32'(periodO), 32'd0);
        checkOutput("midResetHighO", 32'(highO), 32'd0);
        checkOutput("midResetValidO", 32'(validO), 32'd0);
        checkOutput("midResetErrO", 32'(errO), 32'd0);
        checkOutput("midResetLostO", 32'(lostO), 32'd0);
`ifdef CLKMON_STICKY_EN
        checkOutput("midResetSticky", 32'(errStickyO), 32'd0);
`endif
        nRst = 1'b1;
        @(negedge clk50mhzI);
        vcBefore = validCount;
        applyStimulus(2, 3);
        checkOutput("noValidAfterReset", 32'(validCount), 32'(vcBefore));
        applyStimulus(2, 3);

        // Period of exactly TIMEOUT+1: the rise coincides with the timeout and wins
        applyStimulus(2, 63);
        checkOutput("noLostBeforeBound", 32'(lostO), 32'd0);
        applyStimulus(2, 3);
        checkOutput("noLostAtBound", 32'(lostO), 32'd0);
        applyStimulus(2, 3);

        // Let the last measurement drain
        repeat (8) @(negedge clk50mhzI);
        checkOutput("pendingResults", 32'(sbQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
